// File: rtl/i_type_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : i_type_issue_unit
//  Purpose  : Fetch/issue front end for the I-type datapath. Walks a
//             synchronous instruction memory from BASE_ADDR and splits each
//             32-bit word into OpCode/rs/rt/imm. The fields are offered on a
//             valid/ready handshake. Words that are not I-type are skipped
//             and counted. The unit stops on a HALT word, or after the word
//             at LAST_ADDR has been issued or skipped.
//  Ports    : clk          rising-edge clock
//             reset        asynchronous, active-high reset
//             start        begin a run from BASE_ADDR (IDLE/HALT only)
//             imem_en      memory read enable (high only in FETCH)
//             imem_addr    byte address, driven from the pc
//             imem_rdata   read data, valid the cycle after imem_en
//             OpCode/rs/rt/imm  instruction fields (imm is raw, not extended)
//             instr_valid  fields valid
//             instr_ready  datapath accepts the fields
//             done         high while halted
//             skip_count   non-I-type words skipped this run, saturating
//  Revision : 1.0  initial release
// ============================================================================
module i_type_issue_unit #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFC,
  parameter logic [5:0]        HALT_OP   = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [5:0]        OpCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              done,
  output logic [7:0]        skip_count
);

  // I-type opcodes accepted by the datapath
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_andi = 6'b001100;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;

  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_imem_en;
  logic [5:0]        r_opcode;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [15:0]       r_imm;
  logic              r_valid;
  logic              r_done;
  logic [7:0]        r_skip_count;

  logic [5:0]        w_op;
  logic              w_is_halt;
  logic              w_is_itype;
  logic              w_at_last;
  logic [ADDR_W-1:0] w_pc_next;
  logic [7:0]        w_skip_next;

  // --------------------------------------------------------------------------
  // Classification of the word returned by the memory (meaningful in DECODE)
  // --------------------------------------------------------------------------
  assign w_op      = imem_rdata[31:26];
  assign w_is_halt = (w_op == HALT_OP);

  always_comb begin
    w_is_itype = 1'b0;
    case (w_op)
      c_op_addi, c_op_andi, c_op_ori,
      c_op_lw,   c_op_sw,   c_op_beq: w_is_itype = 1'b1;
      default:                        w_is_itype = 1'b0;
    endcase
  end

  assign w_at_last = (r_pc == LAST_ADDR);
  // Word-aligned increment; wraps naturally modulo 2^ADDR_W
  assign w_pc_next = r_pc + c_pc_step;
  assign w_skip_next = (r_skip_count == 8'hFF) ? r_skip_count : r_skip_count + 8'd1;

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= BASE_ADDR;
      r_imem_en    <= 1'b0;
      r_opcode     <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_imm        <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_skip_count <= '0;
    end else begin
      // The read enable is a one-cycle strobe; only a move into FETCH raises it
      r_imem_en <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc         <= BASE_ADDR;
            r_skip_count <= '0;
            r_imem_en    <= 1'b1;
            r_state      <= ST_FETCH;
          end
        end

        // The memory captures imem_addr on the edge leaving this state
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (w_is_halt) begin
            // pc stays on the HALT word
            r_done  <= 1'b1;
            r_state <= ST_HALT;
          end else if (w_is_itype) begin
            r_opcode <= imem_rdata[31:26];
            r_rs     <= imem_rdata[25:21];
            r_rt     <= imem_rdata[20:16];
            r_imm    <= imem_rdata[15:0];
            r_valid  <= 1'b1;
            r_state  <= ST_ISSUE;
          end else begin
            r_skip_count <= w_skip_next;
            if (w_at_last) begin
              r_done  <= 1'b1;
              r_state <= ST_HALT;
            end else begin
              r_pc      <= w_pc_next;
              r_imem_en <= 1'b1;
              r_state   <= ST_FETCH;
            end
          end
        end

        // Fields and valid are held untouched until the datapath accepts them
        ST_ISSUE: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (w_at_last) begin
              r_done  <= 1'b1;
              r_state <= ST_HALT;
            end else begin
              r_pc      <= w_pc_next;
              r_imem_en <= 1'b1;
              r_state   <= ST_FETCH;
            end
          end
        end

        // Fields keep their last values while halted
        ST_HALT: begin
          if (start) begin
            r_pc         <= BASE_ADDR;
            r_skip_count <= '0;
            r_done       <= 1'b0;
            r_imem_en    <= 1'b1;
            r_state      <= ST_FETCH;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_en     = r_imem_en;
  assign imem_addr   = r_pc;
  assign OpCode      = r_opcode;
  assign rs          = r_rs;
  assign rt          = r_rt;
  assign imm         = r_imm;
  assign instr_valid = r_valid;
  assign done        = r_done;
  assign skip_count  = r_skip_count;

endmodule
`default_nettype wire

// File: tb/tb_i_type_issue_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i_type_issue_unit
//  Purpose  : Self-checking bench for i_type_issue_unit. A table of single
//             words, hand sequences for latency/stall/skip/halt/reset, and
//             randomized programs compared against a program-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i_type_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        instr_ready;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [5:0]  OpCode;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic        instr_valid;
  logic        done;
  logic [7:0]  skip_count;

  // Second instance with a short address range
  logic        start5;
  logic        instr_ready5;
  logic        imem_en5;
  logic [7:0]  imem_addr5;
  logic [31:0] imem_rdata5 = '0;
  logic [5:0]  OpCode5;
  logic [4:0]  rs5, rt5;
  logic [15:0] imm5;
  logic        instr_valid5;
  logic        done5;
  logic [7:0]  skip_count5;

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  always @(posedge clk) if (imem_en)  imem_rdata  <= mem[imem_addr[7:2]];
  always @(posedge clk) if (imem_en5) imem_rdata5 <= mem[imem_addr5[7:2]];

  i_type_issue_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .OpCode(OpCode), .rs(rs), .rt(rt), .imm(imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .done(done), .skip_count(skip_count)
  );

  i_type_issue_unit #(.LAST_ADDR(8'h04)) dut5 (
    .clk(clk), .reset(reset), .start(start5),
    .imem_en(imem_en5), .imem_addr(imem_addr5), .imem_rdata(imem_rdata5),
    .OpCode(OpCode5), .rs(rs5), .rt(rt5), .imm(imm5),
    .instr_valid(instr_valid5), .instr_ready(instr_ready5),
    .done(done5), .skip_count(skip_count5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Program-level reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } issue_t;

  issue_t     exp_q[$];
  issue_t     obs_q[$];
  int         exp_skips;
  int         exp_fetches;
  logic [7:0] exp_pc;

  logic [5:0] itype_ops [0:5] = '{6'b001000, 6'b001100, 6'b001101,
                                  6'b100011, 6'b101011, 6'b000100};

  function automatic bit is_itype(input logic [5:0] op);
    for (int i = 0; i < 6; i++) if (itype_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_run(input logic [7:0] last);
    logic [7:0]  pc;
    logic [31:0] w;
    pc = 8'h00;
    exp_q.delete();
    exp_skips   = 0;
    exp_fetches = 0;
    while (1) begin
      w = mem[pc[7:2]];
      exp_fetches++;
      if (w[31:26] == 6'b111111) break;
      if (is_itype(w[31:26])) exp_q.push_back('{pc, w});
      else if (exp_skips < 255) exp_skips++;
      if (pc == last) break;
      pc = pc + 8'd4;
    end
    exp_pc = pc;
  endtask

  function automatic logic [31:0] rand_word(input int mode);
    logic [31:0] w;
    logic [5:0]  op;
    int          r;
    w = $urandom;
    r = (mode == 1) ? 0 : $urandom_range(0, 99);
    if (r < 60) begin
      op = itype_ops[$urandom_range(0, 5)];
    end else if (r < 95) begin
      op = 6'($urandom);
      while (is_itype(op) || op == 6'b111111) op = 6'($urandom);
    end else begin
      op = 6'b111111;
    end
    w[31:26] = op;
    return w;
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) mem[i] = 32'hFC00_0000;
  endtask

  // --------------------------------------------------------------------------
  // Run one program on dut. Observed issues go to obs_q; hold and drop
  // behaviour of the handshake is checked cycle by cycle.
  // --------------------------------------------------------------------------
  task automatic run_dut(input bit rand_ready, input int budget,
                         output int n_fetch, output bit finished);
    logic        prev_valid, prev_ready;
    logic [31:0] prev_fields;
    int          cyc;
    obs_q.delete();
    n_fetch = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    prev_valid  = 1'b0;
    prev_ready  = 1'b0;
    prev_fields = '0;
    cyc         = 0;
    while (!done && cyc < budget) begin
      if (prev_valid && !prev_ready)
        check("hold while stalled", {instr_valid, OpCode, rs, rt, imm}, {1'b1, prev_fields});
      if (prev_valid && prev_ready)
        check("valid drops after handshake", instr_valid, 1'b0);
      if (imem_en) n_fetch++;
      instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      // start must be ignored while a run is in progress
      start = rand_ready ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (instr_valid && instr_ready) obs_q.push_back('{imem_addr, {OpCode, rs, rt, imm}});
      prev_valid  = instr_valid;
      prev_ready  = instr_ready;
      prev_fields = {OpCode, rs, rt, imm};
      @(posedge clk); #1;
      cyc++;
    end
    start       = 1'b0;
    instr_ready = 1'b0;
    finished    = done;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int cyc = 0;
    while (!instr_valid && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!instr_valid) check(name, 1'b0, 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, done, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  // Single-word table: mem[0]=word, everything else HALT
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] word;
    bit          exp_issue;
    int          exp_skip;
    logic [7:0]  exp_pc;
    int          exp_fetch;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    int  nf;
    bit  fin;
    issue_t it;
    int  cnt;

    vecs[0]  = '{32'h2067_0064, 1'b1, 0, 8'h04, 2};  // ADDI
    vecs[1]  = '{32'h30A5_FFFF, 1'b1, 0, 8'h04, 2};  // ANDI
    vecs[2]  = '{32'h3400_0001, 1'b1, 0, 8'h04, 2};  // ORI
    vecs[3]  = '{32'h8C22_0010, 1'b1, 0, 8'h04, 2};  // LW
    vecs[4]  = '{32'hAC22_0010, 1'b1, 0, 8'h04, 2};  // SW
    vecs[5]  = '{32'h1022_0003, 1'b1, 0, 8'h04, 2};  // BEQ
    vecs[6]  = '{32'h0000_0020, 1'b0, 1, 8'h04, 2};  // R-type
    vecs[7]  = '{32'h0800_0010, 1'b0, 1, 8'h04, 2};  // J
    vecs[8]  = '{32'h3C01_1234, 1'b0, 1, 8'h04, 2};  // LUI
    vecs[9]  = '{32'hFC00_0000, 1'b0, 0, 8'h00, 1};  // HALT
    vecs[10] = '{32'hFFFF_FFFF, 1'b0, 0, 8'h00, 1};  // HALT, nonzero fields

    reset        = 1'b1;
    start        = 1'b0;
    instr_ready  = 1'b0;
    start5       = 1'b0;
    instr_ready5 = 1'b0;
    fill_halt();

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", instr_valid, 1'b0);
    check("reset done", done, 1'b0);
    check("reset imem_en", imem_en, 1'b0);
    check("reset imem_addr", imem_addr, 8'h00);
    check("reset skip_count", skip_count, 8'h00);
    check("reset fields", {OpCode, rs, rt, imm}, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle without start", {imem_en, instr_valid, done}, 3'b000);

    // ---------------- table ----------------
    for (int v = 0; v < 11; v++) begin
      fill_halt();
      mem[0] = vecs[v].word;
      run_dut(1'b0, 40, nf, fin);
      check($sformatf("tbl%0d finished", v), fin, 1'b1);
      check($sformatf("tbl%0d issue count", v), obs_q.size(), vecs[v].exp_issue ? 1 : 0);
      if (vecs[v].exp_issue && obs_q.size() > 0) begin
        check($sformatf("tbl%0d fields", v), obs_q[0].word, vecs[v].word);
        check($sformatf("tbl%0d issue addr", v), obs_q[0].addr, 8'h00);
      end
      check($sformatf("tbl%0d skip_count", v), skip_count, 8'(vecs[v].exp_skip));
      check($sformatf("tbl%0d halt pc", v), imem_addr, vecs[v].exp_pc);
      check($sformatf("tbl%0d fetches", v), nf, vecs[v].exp_fetch);
    end

    // ---------------- latency: start at E0 -> valid after E2 ----------------
    fill_halt();
    mem[0] = 32'h2067_0064;
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;                 // after E0
    check("E0 fetch", {instr_valid, imem_en, imem_addr, done}, {1'b0, 1'b1, 8'h00, 1'b0});
    @(posedge clk); #1;                              // after E1
    check("E1 decode", {instr_valid, imem_en}, 2'b00);
    @(posedge clk); #1;                              // after E2
    check("E2 issue valid", instr_valid, 1'b1);
    check("E2 fields", {OpCode, rs, rt, imm}, {6'b001000, 5'd3, 5'd7, 16'd100});
    @(posedge clk); #1;                              // after E3
    check("E3 single-cycle valid", instr_valid, 1'b0);
    wait_done("latency run halts", 20);
    check("halt holds fields", {OpCode, rs, rt, imm}, 32'h2067_0064);
    instr_ready = 1'b0;

    // ---------------- skip, stall, halt, restart ----------------
    fill_halt();
    mem[0] = 32'h0000_0020;
    mem[1] = 32'h2086_00C8;
    mem[2] = 32'hFC00_0000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid("stall seq reaches issue", 20);
    check("issue after skip addr", imem_addr, 8'h04);
    check("skip counted", skip_count, 8'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall %0d", k), {instr_valid, rs, rt, imm}, {1'b1, 5'd4, 5'd6, 16'd200});
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    check("single handshake", instr_valid, 1'b0);
    wait_done("halt word reached", 20);
    check("halt pc not advanced", imem_addr, 8'h08);
    check("no valid in halt", instr_valid, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart", {imem_addr, done, imem_en, skip_count}, {8'h00, 1'b0, 1'b1, 8'h00});

    // ---------------- asynchronous reset in ISSUE ----------------
    wait_valid("reset seq reaches issue", 20);
    #2 reset = 1'b1;
    #1;
    check("async reset", {instr_valid, done, imem_addr, imem_en}, {1'b0, 1'b0, 8'h00, 1'b0});
    @(negedge clk) reset = 1'b0;
    instr_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (instr_valid || imem_en) cnt++;
    end
    check("dropped word never issued", cnt, 0);
    instr_ready = 1'b0;

    // ---------------- LAST_ADDR = 0x04 ----------------
    fill_halt();
    mem[0] = 32'h2067_0064;
    mem[1] = 32'h2086_00C8;
    mem[2] = 32'h2001_0001;
    instr_ready5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30 && !done5; k++) begin
      if (instr_valid5 && instr_ready5) cnt++;
      @(posedge clk); #1;
    end
    check("last addr issues", cnt, 2);
    check("last addr done", done5, 1'b1);
    check("last addr pc", imem_addr5, 8'h04);

    // ---------------- randomized programs ----------------
    for (int r = 0; r < 7; r++) begin
      int mode = (r == 6) ? 1 : 0;
      for (int i = 0; i < 64; i++) mem[i] = rand_word(mode);
      model_run(8'hFC);
      run_dut(1'b1, 3000, nf, fin);
      check($sformatf("rnd%0d finished", r), fin, 1'b1);
      check($sformatf("rnd%0d issue count", r), obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check($sformatf("rnd%0d issue @%0h", r, it.addr), {obs_q[0].addr, obs_q[0].word}, {it.addr, it.word});
        void'(obs_q.pop_front());
      end
      check($sformatf("rnd%0d skip_count", r), skip_count, 8'(exp_skips));
      check($sformatf("rnd%0d halt pc", r), imem_addr, exp_pc);
      check($sformatf("rnd%0d fetches", r), nf, exp_fetches);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
